// File: rtl/k_sort_if.sv
// Sample stream into the K-nearest selector: one (distance, type) pair per
// beat with a valid/ready handshake and an end-of-query marker.
interface k_sort_if #(
  parameter int TYPE_W = 2,
  parameter int DIST_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DIST_W-1:0] in_dist;
  logic [TYPE_W-1:0] in_type;
  logic              in_last;

  modport master (
    output in_valid,
    output in_dist,
    output in_type,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_dist,
    input  in_type,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/k_sort.sv
// Streaming K-nearest selector. Keeps the K smallest distances of a query in
// an ordered register table (slot 0 nearest, empty slots at the tail) and
// publishes the neighbour types and distances once the last sample arrives.
module k_sort #(
  parameter int K      = 3,
  parameter int TYPE_W = 2,
  parameter int DIST_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  k_sort_if.slave                  in_bus,
  output logic [TYPE_W*K-1:0]      k_nearest_neighbours_type,
  output logic [DIST_W*K-1:0]      k_nearest_neighbours_dist,
  output logic [$clog2(K+1)-1:0]   num_valid,
  output logic                     valid_sort
);

  localparam int NUM_W = $clog2(K+1);

  typedef enum logic {COLLECT, DONE} state_t;

  state_t            state;
  logic              tbl_occ  [K];
  logic [DIST_W-1:0] tbl_dist [K];
  logic [TYPE_W-1:0] tbl_type [K];

  logic              nxt_occ  [K];
  logic [DIST_W-1:0] nxt_dist [K];
  logic [TYPE_W-1:0] nxt_type [K];

  logic              le [K];
  logic              accept;
  logic [NUM_W-1:0]  occ_count;

  assign in_bus.in_ready = (state == COLLECT);
  assign accept          = in_bus.in_valid && (state == COLLECT);

  // A slot stays put when it is occupied and not farther than the new sample;
  // since the table is sorted this forms a thermometer code, so ties keep
  // earlier arrivals ahead of the newcomer.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      le[i] = tbl_occ[i] && (tbl_dist[i] <= in_bus.in_dist);
    end
  end

  // Next table after inserting the sample: the first slot that does not stay
  // takes the sample, every slot behind it takes its predecessor; the old tail
  // falls off, and a sample behind a full table changes nothing.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      nxt_occ[i]  = tbl_occ[i];
      nxt_dist[i] = tbl_dist[i];
      nxt_type[i] = tbl_type[i];
    end
    if (!le[0]) begin
      nxt_occ[0]  = 1'b1;
      nxt_dist[0] = in_bus.in_dist;
      nxt_type[0] = in_bus.in_type;
    end
    for (int i = 1; i < K; i++) begin
      if (!le[i]) begin
        if (le[i-1]) begin
          nxt_occ[i]  = 1'b1;
          nxt_dist[i] = in_bus.in_dist;
          nxt_type[i] = in_bus.in_type;
        end else begin
          nxt_occ[i]  = tbl_occ[i-1];
          nxt_dist[i] = tbl_dist[i-1];
          nxt_type[i] = tbl_type[i-1];
        end
      end
    end
  end

  // Number of filled slots, published as num_valid at end of query.
  always_comb begin
    occ_count = '0;
    for (int i = 0; i < K; i++) begin
      if (tbl_occ[i]) occ_count = occ_count + NUM_W'(1);
    end
  end

  // Collect/publish controller: owns the table and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                     <= COLLECT;
      valid_sort                <= 1'b0;
      num_valid                 <= '0;
      k_nearest_neighbours_type <= '0;
      k_nearest_neighbours_dist <= '0;
      for (int i = 0; i < K; i++) begin
        tbl_occ[i]  <= 1'b0;
        tbl_dist[i] <= '0;
        tbl_type[i] <= '0;
      end
    end else begin
      case (state)
        COLLECT: begin
          valid_sort <= 1'b0;
          if (accept) begin
            for (int i = 0; i < K; i++) begin
              tbl_occ[i]  <= nxt_occ[i];
              tbl_dist[i] <= nxt_dist[i];
              tbl_type[i] <= nxt_type[i];
            end
            if (in_bus.in_last) state <= DONE;
          end
        end
        DONE: begin
          for (int i = 0; i < K; i++) begin
            k_nearest_neighbours_type[i*TYPE_W +: TYPE_W] <= tbl_occ[i] ? tbl_type[i] : '0;
            k_nearest_neighbours_dist[i*DIST_W +: DIST_W] <= tbl_occ[i] ? tbl_dist[i] : '1;
            tbl_occ[i] <= 1'b0;
          end
          num_valid  <= occ_count;
          valid_sort <= 1'b1;
          state      <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
